// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibits the bus, issues a request-to-send,
// then shifts one odd-parity byte out on device clock falls and checks the ACK.
module ps2_host_tx #(
    parameter int unsigned CLK_HZ         = 12000000,
    parameter int unsigned INHIBIT_CYCLES = 1200,
    parameter int unsigned TIMEOUT_CYCLES = 180000,
    parameter int unsigned FILTER_LEN     = 4
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [7:0] tx_data_i,
    input  logic       tx_start_i,
    output logic       busy_o,
    output logic       done_o,
    output logic       error_o,
    input  logic       ps2clk_i,
    input  logic       ps2data_i,
    output logic       ps2clk_oe_o,
    output logic       ps2data_oe_o
);

    localparam int unsigned CntMaxVal =
        (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int unsigned CntW = $clog2(CntMaxVal + 1);

    // Bit-edge reaction (sync + filter + edge detect) must fit well inside the
    // 30 us low half-period of the device clock.
    if ((FILTER_LEN + 3) * 1000000 >= 30 * CLK_HZ) begin : g_latency_check
        $error("ps2_host_tx: edge latency too long for CLK_HZ");
    end

    typedef enum logic [2:0] {
        StIdle,
        StInhibit,
        StReq,
        StSend,
        StWaitIdle,
        StDone,
        StError
    } state_e;

    state_e              state_q, state_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [9:0]          frame_q, frame_d;
    logic [3:0]          edge_q, edge_d;
    logic                data_oe_q, data_oe_d;

    logic [1:0]            clk_sync_q, data_sync_q;
    logic [FILTER_LEN-1:0] clk_hist_q, data_hist_q;
    logic                  clk_filt_q, data_filt_q, clk_filt_prev_q;
    logic                  clk_fall;
    logic                  timeout;

    // Idle bus level is high, so the conditioning chain resets to all ones.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            clk_sync_q      <= '1;
            data_sync_q     <= '1;
            clk_hist_q      <= '1;
            data_hist_q     <= '1;
            clk_filt_q      <= 1'b1;
            data_filt_q     <= 1'b1;
            clk_filt_prev_q <= 1'b1;
        end else begin
            clk_sync_q      <= {clk_sync_q[0], ps2clk_i};
            data_sync_q     <= {data_sync_q[0], ps2data_i};
            clk_hist_q      <= FILTER_LEN'({clk_hist_q, clk_sync_q[1]});
            data_hist_q     <= FILTER_LEN'({data_hist_q, data_sync_q[1]});
            clk_filt_prev_q <= clk_filt_q;
            if (&clk_hist_q) begin
                clk_filt_q <= 1'b1;
            end else if (~|clk_hist_q) begin
                clk_filt_q <= 1'b0;
            end
            if (&data_hist_q) begin
                data_filt_q <= 1'b1;
            end else if (~|data_hist_q) begin
                data_filt_q <= 1'b0;
            end
        end
    end

    assign clk_fall = clk_filt_prev_q & ~clk_filt_q;
    assign timeout  = (cnt_q == CntW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            frame_q   <= '0;
            edge_q    <= '0;
            data_oe_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            frame_q   <= frame_d;
            edge_q    <= edge_d;
            data_oe_q <= data_oe_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = (&cnt_q) ? cnt_q : cnt_q + CntW'(1);
        frame_d   = frame_q;
        edge_d    = edge_q;
        data_oe_d = data_oe_q;
        unique case (state_q)
            StIdle: begin
                cnt_d     = '0;
                data_oe_d = 1'b0;
                if (tx_start_i) begin
                    frame_d = {1'b1, ~^tx_data_i, tx_data_i};
                    state_d = StInhibit;
                end
            end
            StInhibit: begin
                if (cnt_q == CntW'(INHIBIT_CYCLES - 1)) begin
                    state_d   = StReq;
                    cnt_d     = '0;
                    edge_d    = '0;
                    data_oe_d = 1'b1;
                end
            end
            StReq: begin
                if (clk_fall) begin
                    state_d   = StSend;
                    cnt_d     = '0;
                    edge_d    = 4'd1;
                    data_oe_d = ~frame_q[0];
                end else if (timeout) begin
                    state_d = StError;
                end
            end
            StSend: begin
                if (clk_fall) begin
                    cnt_d = '0;
                    if (edge_q == 4'd10) begin
                        // 11th fall: device must be holding data low as ACK.
                        data_oe_d = 1'b0;
                        state_d   = data_filt_q ? StError : StWaitIdle;
                    end else begin
                        edge_d    = edge_q + 4'd1;
                        data_oe_d = ~frame_q[edge_q];
                    end
                end else if (timeout) begin
                    state_d = StError;
                end
            end
            StWaitIdle: begin
                data_oe_d = 1'b0;
                if (clk_filt_q && data_filt_q) begin
                    state_d = StDone;
                end else if (timeout) begin
                    state_d = StError;
                end
            end
            StDone, StError: begin
                data_oe_d = 1'b0;
                state_d   = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Start bit goes low in the final inhibit cycle so data leads clock release.
    always_comb begin
        ps2clk_oe_o  = (state_q == StInhibit);
        ps2data_oe_o = ((state_q == StInhibit) && (cnt_q == CntW'(INHIBIT_CYCLES - 1))) ||
                       (((state_q == StReq) || (state_q == StSend)) && data_oe_q);
        busy_o       = (state_q != StIdle);
        done_o       = (state_q == StDone);
        error_o      = (state_q == StError);
    end

endmodule
